// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - J1 I/O bus arbiter: CPU absolute priority, queued secondary master
// Optional feature: define IO_ARB_STATS_EN to add the m2_count completion counter port.
module io_bus_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        cpu_io_rd,
  input  logic        cpu_io_wr,
  input  logic [15:0] cpu_io_addr,
  input  logic [15:0] cpu_io_dout,
  output logic [15:0] cpu_io_din,
  input  logic        m2_req_valid,
  output logic        m2_req_ready,
  input  logic        m2_req_wr,
  input  logic [15:0] m2_req_addr,
  input  logic [15:0] m2_req_wdata,
  output logic        m2_rsp_valid,
  output logic [15:0] m2_rsp_data,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_dout,
  input  logic [15:0] bus_din
`ifdef IO_ARB_STATS_EN
  ,
  output logic [15:0] m2_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic [AW:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        mem_wr_q    [FIFO_DEPTH];
  logic        mem_wr_d    [FIFO_DEPTH];
  logic [15:0] mem_addr_q  [FIFO_DEPTH];
  logic [15:0] mem_addr_d  [FIFO_DEPTH];
  logic [15:0] mem_wdata_q [FIFO_DEPTH];
  logic [15:0] mem_wdata_d [FIFO_DEPTH];
  logic [15:0] rsp_data_q, rsp_data_d;
`ifdef IO_ARB_STATS_EN
  logic [15:0] stat_q, stat_d;
`endif

  logic        cpu_act, full, empty, push, pop, rsp_fire, more;
  logic        head_wr;
  logic [15:0] head_addr, head_wdata;

  // Queue status, accept handshake and head-of-queue view
  always_comb begin
    cpu_act      = cpu_io_rd | cpu_io_wr;
    full         = (count_q == (AW+1)'(FIFO_DEPTH));
    empty        = (count_q == '0);
    m2_req_ready = !full && !sys_rst_i;
    push         = m2_req_valid && m2_req_ready;
    head_wr      = mem_wr_q[rd_ptr_q];
    head_addr    = mem_addr_q[rd_ptr_q];
    head_wdata   = mem_wdata_q[rd_ptr_q];
    // Something is still queued after popping the head (counting a same-cycle accept)
    more         = (count_q > (AW+1)'(1)) || push;
  end

  // Secondary-master sequencer: issue head when the CPU is quiet, retry on any CPU strobe
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pop        = 1'b0;
    rsp_fire   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!cpu_act) begin
          if (head_wr) begin
            pop     = 1'b1;
            state_d = more ? ST_ISSUE : ST_IDLE;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = 2'(RD_LATENCY);
          end
        end
      end
      ST_WAIT: begin
        if (cpu_act) begin
          // CPU may have disturbed the read path; redo the whole read
          state_d = ST_ISSUE;
        end else if (wait_cnt_q == 2'd1) begin
          rsp_fire = 1'b1;
          pop      = 1'b1;
          state_d  = more ? ST_ISSUE : ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO storage and pointer updates
  always_comb begin
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (push) begin
      mem_wr_d[wr_ptr_q]    = m2_req_wr;
      mem_addr_d[wr_ptr_q]  = m2_req_addr;
      mem_wdata_d[wr_ptr_q] = m2_req_wdata;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // Shared bus mux: CPU first, then the secondary head, else mirror the CPU idle
  always_comb begin
    bus_rd   = 1'b0;
    bus_wr   = 1'b0;
    bus_addr = cpu_io_addr;
    bus_dout = cpu_io_dout;
    if (cpu_act) begin
      bus_rd = cpu_io_rd;
      bus_wr = cpu_io_wr;
    end else if (state_q == ST_ISSUE) begin
      bus_addr = head_addr;
      bus_dout = head_wdata;
      bus_rd   = !head_wr;
      bus_wr   = head_wr;
    end else if (state_q == ST_WAIT) begin
      bus_addr = head_addr;
      bus_dout = head_wdata;
    end
  end

  // Response path: data is bypassed in the capture cycle so it is valid with the pulse
  always_comb begin
    cpu_io_din   = bus_din;
    m2_rsp_valid = rsp_fire;
    rsp_data_d   = rsp_fire ? bus_din : rsp_data_q;
    m2_rsp_data  = rsp_data_d;
`ifdef IO_ARB_STATS_EN
    stat_d       = stat_q + 16'(pop);
    m2_count     = stat_q;
`endif
  end

  // State registers; reset drops every queued and in-flight request
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rsp_data_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_wr_q[i]    <= 1'b0;
        mem_addr_q[i]  <= '0;
        mem_wdata_q[i] <= '0;
      end
`ifdef IO_ARB_STATS_EN
      stat_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rsp_data_q  <= rsp_data_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef IO_ARB_STATS_EN
      stat_q      <= stat_d;
`endif
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - self-checking bench for io_bus_arbiter
module tb_io_bus_arbiter;

  localparam int DEPTH = 2;
  localparam int LAT   = 1;

  logic        sys_clk_i = 1'b0;
  logic        sys_rst_i = 1'b1;
  logic        cpu_io_rd = 1'b0, cpu_io_wr = 1'b0;
  logic [15:0] cpu_io_addr = '0, cpu_io_dout = '0;
  logic [15:0] cpu_io_din;
  logic        m2_req_valid = 1'b0, m2_req_wr = 1'b0;
  logic        m2_req_ready;
  logic [15:0] m2_req_addr = '0, m2_req_wdata = '0;
  logic        m2_rsp_valid;
  logic [15:0] m2_rsp_data;
  logic        bus_rd, bus_wr;
  logic [15:0] bus_addr, bus_dout;
  logic [15:0] bus_din = '0;
`ifdef IO_ARB_STATS_EN
  logic [15:0] m2_count;
`endif

  io_bus_arbiter #(.FIFO_DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
    .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
    .cpu_io_rd(cpu_io_rd), .cpu_io_wr(cpu_io_wr),
    .cpu_io_addr(cpu_io_addr), .cpu_io_dout(cpu_io_dout), .cpu_io_din(cpu_io_din),
    .m2_req_valid(m2_req_valid), .m2_req_ready(m2_req_ready), .m2_req_wr(m2_req_wr),
    .m2_req_addr(m2_req_addr), .m2_req_wdata(m2_req_wdata),
    .m2_rsp_valid(m2_rsp_valid), .m2_rsp_data(m2_rsp_data),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_dout(bus_dout),
    .bus_din(bus_din)
`ifdef IO_ARB_STATS_EN
    , .m2_count(m2_count)
`endif
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int tests = 0;
  int fails = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_io_rd    = 1'b0;
    cpu_io_wr    = 1'b0;
    m2_req_valid = 1'b0;
    bus_din      = '0;
  endtask

  task automatic do_reset();
    @(negedge sys_clk_i);
    sys_rst_i = 1'b1;
    idle_inputs();
    @(negedge sys_clk_i);
    @(negedge sys_clk_i);
    sys_rst_i = 1'b0;
  endtask

  task automatic set_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    m2_req_valid = 1'b1;
    m2_req_wr    = wr;
    m2_req_addr  = addr;
    m2_req_wdata = wdata;
  endtask

  // Transaction-level reference model: ordered queue of accepted requests
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;
  req_t        mq[$];
  bit          pend;
  int          pend_age;
  logic [15:0] m_cnt;

  task automatic rand_cycle(input bit allow_cpu, input bit allow_req);
    int   r;
    logic exp_ready, act;
    req_t nr;
    @(negedge sys_clk_i);
    r            = allow_cpu ? int'($urandom_range(0, 9)) : 9;
    cpu_io_rd    = (r < 2);
    cpu_io_wr    = (r == 2);
    cpu_io_addr  = 16'($urandom);
    cpu_io_dout  = 16'($urandom);
    m2_req_valid = allow_req && ($urandom_range(0, 1) == 1);
    m2_req_wr    = ($urandom_range(0, 1) == 1);
    m2_req_addr  = 16'($urandom);
    m2_req_wdata = 16'($urandom);
    bus_din      = 16'($urandom);
    #1;
    act       = cpu_io_rd | cpu_io_wr;
    exp_ready = (mq.size() < DEPTH);
    chk1("rand_ready", m2_req_ready, exp_ready);
    chk16("rand_cpu_din", cpu_io_din, bus_din);
`ifdef IO_ARB_STATS_EN
    chk16("rand_m2_count", m2_count, m_cnt);
`endif
    if (act) begin
      chk1("rand_cpu_rd", bus_rd, cpu_io_rd);
      chk1("rand_cpu_wr", bus_wr, cpu_io_wr);
      chk16("rand_cpu_addr", bus_addr, cpu_io_addr);
      chk16("rand_cpu_dout", bus_dout, cpu_io_dout);
      chk1("rand_rsp_in_cpu_cycle", m2_rsp_valid, 1'b0);
      pend = 1'b0;
    end else if (pend) begin
      pend_age++;
      chk1("rand_wait_rd", bus_rd, 1'b0);
      chk1("rand_wait_wr", bus_wr, 1'b0);
      chk16("rand_wait_addr", bus_addr, mq[0].addr);
      if (pend_age == LAT) begin
        chk1("rand_rsp_valid", m2_rsp_valid, 1'b1);
        chk16("rand_rsp_data", m2_rsp_data, bus_din);
        void'(mq.pop_front());
        m_cnt = m_cnt + 16'd1;
        pend  = 1'b0;
      end else begin
        chk1("rand_rsp_early", m2_rsp_valid, 1'b0);
      end
    end else begin
      chk1("rand_rsp_spurious", m2_rsp_valid, 1'b0);
      if (bus_rd || bus_wr) begin
        if (mq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rand_strobe_empty: strobe rd=%b wr=%b with no queued request", bus_rd, bus_wr);
        end else begin
          chk1("rand_kind", bus_wr, mq[0].wr);
          chk1("rand_both", bus_rd && bus_wr, 1'b0);
          chk16("rand_m2_addr", bus_addr, mq[0].addr);
          if (mq[0].wr) begin
            chk16("rand_m2_wdata", bus_dout, mq[0].wdata);
            void'(mq.pop_front());
            m_cnt = m_cnt + 16'd1;
          end else begin
            pend     = 1'b1;
            pend_age = 0;
          end
        end
      end
    end
    if (m2_req_valid && exp_ready) begin
      nr.wr    = m2_req_wr;
      nr.addr  = m2_req_addr;
      nr.wdata = m2_req_wdata;
      mq.push_back(nr);
    end
  endtask

  typedef struct {
    logic        rd, wr;
    logic [15:0] addr, dout, din;
    logic        e_rd, e_wr;
    logic [15:0] e_addr, e_dout, e_din;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int n;
    int idx;
    int seen;
    logic [15:0] got[$];

    vecs[0] = '{1'b0, 1'b1, 16'h6704, 16'h1234, 16'h0000, 1'b0, 1'b1, 16'h6704, 16'h1234, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h6800, 16'h5555, 16'h00C3, 1'b1, 1'b0, 16'h6800, 16'h5555, 16'h00C3};
    vecs[2] = '{1'b0, 1'b0, 16'hABCD, 16'h9876, 16'h4321, 1'b0, 1'b0, 16'hABCD, 16'h9876, 16'h4321};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'hFFFF};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'h8000};

    // Reset values: ready low, CPU strobes pass through, no response
    @(negedge sys_clk_i);
    cpu_io_wr   = 1'b1;
    cpu_io_addr = 16'h1111;
    cpu_io_dout = 16'h2222;
    set_req(1'b1, 16'h7777, 16'h8888);
    #1;
    chk1("rst_ready", m2_req_ready, 1'b0);
    chk1("rst_bus_wr", bus_wr, 1'b1);
    chk16("rst_bus_addr", bus_addr, 16'h1111);
    chk1("rst_rsp_valid", m2_rsp_valid, 1'b0);
    chk16("rst_rsp_data", m2_rsp_data, 16'h0000);
`ifdef IO_ARB_STATS_EN
    chk16("rst_m2_count", m2_count, 16'h0000);
`endif
    @(negedge sys_clk_i);
    sys_rst_i = 1'b0;
    idle_inputs();
    #1;
    chk1("rel_ready", m2_req_ready, 1'b1);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk_i);
      #1;
      if (bus_rd || bus_wr) n++;
    end
    chk16("rst_no_accept", 16'(n), 16'd0);

    // CPU pass-through table with an empty queue
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk_i);
      cpu_io_rd   = vecs[i].rd;
      cpu_io_wr   = vecs[i].wr;
      cpu_io_addr = vecs[i].addr;
      cpu_io_dout = vecs[i].dout;
      bus_din     = vecs[i].din;
      #1;
      chk1("vec_bus_rd", bus_rd, vecs[i].e_rd);
      chk1("vec_bus_wr", bus_wr, vecs[i].e_wr);
      chk16("vec_bus_addr", bus_addr, vecs[i].e_addr);
      chk16("vec_bus_dout", bus_dout, vecs[i].e_dout);
      chk16("vec_cpu_din", cpu_io_din, vecs[i].e_din);
      chk1("vec_ready", m2_req_ready, 1'b1);
    end

    // Secondary write with the CPU idle: strobe two cycles after accept
    do_reset();
    @(negedge sys_clk_i);
    set_req(1'b1, 16'h7010, 16'hBEEF);
    #1;
    chk1("wr_c0_ready", m2_req_ready, 1'b1);
    @(negedge sys_clk_i);
    m2_req_valid = 1'b0;
    #1;
    chk1("wr_c1_bus_wr", bus_wr, 1'b0);
    chk1("wr_c1_ready", m2_req_ready, 1'b1);
    @(negedge sys_clk_i);
    #1;
    chk1("wr_c2_bus_wr", bus_wr, 1'b1);
    chk1("wr_c2_bus_rd", bus_rd, 1'b0);
    chk16("wr_c2_addr", bus_addr, 16'h7010);
    chk16("wr_c2_dout", bus_dout, 16'hBEEF);
    chk1("wr_c2_ready", m2_req_ready, 1'b1);
    @(negedge sys_clk_i);
    #1;
    chk1("wr_c3_bus_wr", bus_wr, 1'b0);

    // Secondary read, latency 1
    do_reset();
    @(negedge sys_clk_i);
    set_req(1'b0, 16'h6902, 16'h0000);
    @(negedge sys_clk_i);
    m2_req_valid = 1'b0;
    @(negedge sys_clk_i);
    #1;
    chk1("rd_strobe", bus_rd, 1'b1);
    chk16("rd_addr", bus_addr, 16'h6902);
    @(negedge sys_clk_i);
    bus_din = 16'h00A5;
    #1;
    chk1("rd_rsp_valid", m2_rsp_valid, 1'b1);
    chk16("rd_rsp_data", m2_rsp_data, 16'h00A5);
    chk1("rd_wait_strobe", bus_rd, 1'b0);
    chk16("rd_wait_addr", bus_addr, 16'h6902);
    @(negedge sys_clk_i);
    bus_din = 16'h0000;
    #1;
    chk1("rd_rsp_pulse_end", m2_rsp_valid, 1'b0);
    chk16("rd_rsp_hold", m2_rsp_data, 16'h00A5);

    // Collision in the ISSUE cycle
    do_reset();
    @(negedge sys_clk_i);
    set_req(1'b1, 16'h7020, 16'h1111);
    @(negedge sys_clk_i);
    m2_req_valid = 1'b0;
    @(negedge sys_clk_i);
    cpu_io_rd   = 1'b1;
    cpu_io_addr = 16'h6800;
    #1;
    chk1("col_cpu_rd", bus_rd, 1'b1);
    chk1("col_cpu_wr", bus_wr, 1'b0);
    chk16("col_cpu_addr", bus_addr, 16'h6800);
    @(negedge sys_clk_i);
    cpu_io_rd = 1'b0;
    #1;
    chk1("col_retry_wr", bus_wr, 1'b1);
    chk16("col_retry_addr", bus_addr, 16'h7020);
    n = (bus_wr || bus_rd) ? 1 : 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk_i);
      #1;
      if (bus_wr || bus_rd) n++;
    end
    chk16("col_strobe_count", 16'(n), 16'd1);

    // Full queue under continuous CPU strobes, then in-order drain
    do_reset();
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge sys_clk_i);
      cpu_io_wr   = 1'b1;
      cpu_io_addr = 16'h6000;
      if (idx < 3) set_req(1'b1, 16'h7100 + 16'(idx), 16'hA000 + 16'(idx));
      else m2_req_valid = 1'b0;
      #1;
      if (m2_req_valid && m2_req_ready) idx++;
    end
    chk16("full_accepts", 16'(idx), 16'd2);
    chk1("full_ready", m2_req_ready, 1'b0);
    got.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge sys_clk_i);
      cpu_io_wr = 1'b0;
      if (idx < 3) set_req(1'b1, 16'h7100 + 16'(idx), 16'hA000 + 16'(idx));
      else m2_req_valid = 1'b0;
      #1;
      if (bus_wr) got.push_back(bus_addr);
      if (m2_req_valid && m2_req_ready) idx++;
    end
    m2_req_valid = 1'b0;
    chk16("full_total_accepts", 16'(idx), 16'd3);
    chk16("full_issue_count", 16'(got.size()), 16'd3);
    for (int i = 0; i < 3; i++)
      chk16("full_order", (i < got.size()) ? got[i] : 16'hXXXX, 16'h7100 + 16'(i));

    // CPU strobe during WAIT aborts and reissues the read
    do_reset();
    @(negedge sys_clk_i);
    set_req(1'b0, 16'h6A00, 16'h0000);
    @(negedge sys_clk_i);
    m2_req_valid = 1'b0;
    @(negedge sys_clk_i);
    #1;
    chk1("abt_first_strobe", bus_rd, 1'b1);
    @(negedge sys_clk_i);
    cpu_io_rd   = 1'b1;
    cpu_io_addr = 16'h6801;
    bus_din     = 16'h1234;
    #1;
    chk1("abt_no_rsp", m2_rsp_valid, 1'b0);
    chk16("abt_cpu_addr", bus_addr, 16'h6801);
    @(negedge sys_clk_i);
    cpu_io_rd = 1'b0;
    #1;
    chk1("abt_reissue_rd", bus_rd, 1'b1);
    chk16("abt_reissue_addr", bus_addr, 16'h6A00);
    @(negedge sys_clk_i);
    bus_din = 16'h5A5A;
    #1;
    chk1("abt_rsp_valid", m2_rsp_valid, 1'b1);
    chk16("abt_rsp_data", m2_rsp_data, 16'h5A5A);
    n = m2_rsp_valid ? 1 : 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk_i);
      #1;
      if (m2_rsp_valid) n++;
    end
    chk16("abt_rsp_count", 16'(n), 16'd1);
`ifdef IO_ARB_STATS_EN
    chk16("abt_m2_count", m2_count, 16'd1);
`endif

    // Reset during WAIT drops the read and clears the counter
    do_reset();
    @(negedge sys_clk_i);
    set_req(1'b1, 16'h7300, 16'h0303);
    @(negedge sys_clk_i);
    set_req(1'b0, 16'h6B00, 16'h0000);
    seen = 0;
    for (int c = 0; c < 8 && seen == 0; c++) begin
      @(negedge sys_clk_i);
      m2_req_valid = 1'b0;
      #1;
      if (bus_rd) seen = 1;
    end
    chk16("rmr_read_seen", 16'(seen), 16'd1);
`ifdef IO_ARB_STATS_EN
    chk16("rmr_count_before", m2_count, 16'd1);
`endif
    @(negedge sys_clk_i);
    sys_rst_i = 1'b1;
    bus_din   = 16'hC0DE;
    #1;
    chk1("rmr_rsp_in_reset", m2_rsp_valid, 1'b0);
    chk1("rmr_ready_in_reset", m2_req_ready, 1'b0);
    @(negedge sys_clk_i);
    sys_rst_i = 1'b0;
    n = 0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge sys_clk_i);
      #1;
      if (m2_rsp_valid) n++;
      if (bus_rd || bus_wr) seen++;
    end
    chk16("rmr_no_rsp", 16'(n), 16'd0);
    chk16("rmr_fifo_empty", 16'(seen), 16'd0);
    chk16("rmr_rsp_data", m2_rsp_data, 16'h0000);
`ifdef IO_ARB_STATS_EN
    chk16("rmr_m2_count", m2_count, 16'd0);
`endif

    // Randomized traffic against the transaction-level model
    do_reset();
    mq.delete();
    pend  = 1'b0;
    pend_age = 0;
    m_cnt = '0;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1, 1'b1);
    for (int c = 0; c < 60 && (mq.size() != 0 || pend); c++) rand_cycle(1'b0, 1'b0);
    chk16("rand_drain_left", 16'(mq.size()), 16'd0);
    chk1("rand_drain_pend", pend, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
